// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit driving a word-only data memory
//
// Purpose:
//   Turns LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned memory
//   accesses. It extracts and extends the addressed lane on loads, and it
//   performs a read-modify-write for sub-word stores. Misaligned, illegal
//   and out-of-range requests are rejected before they reach memory.
//
// Ports:
//   Clk, reset          clock, synchronous active-high reset
//   Req / Ready         request handshake (accept on Req && Ready)
//   IsStore, Funct3     operation select
//   Addr, StoreData     byte address, store source (rs2)
//   Done, Fault         one-cycle completion pulse, rejection flag
//   LoadData            extended load result, held between loads
//   MemAddress, MemWriteData, MemWrite, MemRead, MemReadData
//                       word-wide data memory port (combinational read)

module load_store_unit #(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        Req,
    output logic        Ready,
    input  logic        IsStore,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic        Done,
    output logic        Fault,
    output logic [31:0] LoadData,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] MemReadData
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RMW_READ = 3'd2,
        S_WRITE    = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_store_data;
    logic        r_fault;
    logic [31:0] r_merged;
    logic [31:0] r_load_data;

    logic        w_accept;
    logic        w_bad_f3;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_fault;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_merged;

    assign w_accept = Req && Ready;

    // Request checks, evaluated on the live inputs so the decision is
    // ready at the accept edge.
    always_comb begin
        w_bad_f3     = 1'b0;
        w_misaligned = 1'b0;
        if (IsStore) begin
            w_bad_f3 = !((Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010));
        end else begin
            w_bad_f3 = (Funct3 == 3'b011) || (Funct3[2:1] == 2'b11);
        end
        // Funct3[1:0] encodes access size for every legal op (00 byte,
        // 01 half, 10 word); illegal codes are already faulted above.
        case (Funct3[1:0])
            2'b01:   w_misaligned = Addr[0];
            2'b10:   w_misaligned = (Addr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
        w_out_of_range = (Addr >= 32'(MEM_BYTES));
        w_fault        = w_bad_f3 || w_misaligned || w_out_of_range;
    end

    // Lane extraction from the word returned by memory.
    always_comb begin
        case (r_addr[1:0])
            2'b00:   w_byte = MemReadData[7:0];
            2'b01:   w_byte = MemReadData[15:8];
            2'b10:   w_byte = MemReadData[23:16];
            default: w_byte = MemReadData[31:24];
        endcase
        w_half = r_addr[1] ? MemReadData[31:16] : MemReadData[15:0];
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_ext = {24'd0, w_byte};
            3'b101:  w_load_ext = {16'd0, w_half};
            default: w_load_ext = MemReadData;
        endcase
    end

    // Merge the store lane into the word read back during RMW_READ.
    always_comb begin
        w_merged = MemReadData;
        if (r_funct3[1:0] == 2'b00) begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_store_data[7:0];
        end else begin
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_store_data[15:0];
        end
    end

    // FSM: state register
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_fault) begin
                        w_next = S_RESP;
                    end else if (!IsStore) begin
                        w_next = S_LOAD;
                    end else if (Funct3 == 3'b010) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_RMW_READ;
                    end
                end
            end
            S_LOAD:     w_next = S_RESP;
            S_RMW_READ: w_next = S_WRITE;
            S_WRITE:    w_next = S_RESP;
            S_RESP:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // FSM: outputs. Memory strobes and the response are gated by reset so
    // an aborted access can never commit or complete.
    always_comb begin
        Ready        = (r_state == S_IDLE) && !reset;
        MemRead      = ((r_state == S_LOAD) || (r_state == S_RMW_READ)) && !reset;
        MemWrite     = (r_state == S_WRITE) && !reset;
        MemWriteData = 32'd0;
        if (MemWrite) begin
            MemWriteData = (r_funct3[1:0] == 2'b10) ? r_store_data : r_merged;
        end
        Done         = (r_state == S_RESP) && !reset;
        Fault        = (r_state == S_RESP) && r_fault && !reset;
    end

    // Datapath registers
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_funct3     <= 3'd0;
            r_addr       <= 32'd0;
            r_store_data <= 32'd0;
            r_fault      <= 1'b0;
            r_merged     <= 32'd0;
            r_load_data  <= 32'd0;
        end else begin
            if (w_accept) begin
                r_funct3     <= Funct3;
                r_addr       <= Addr;
                r_store_data <= StoreData;
                r_fault      <= w_fault;
            end
            if (r_state == S_LOAD) begin
                r_load_data <= w_load_ext;
            end
            if (r_state == S_RMW_READ) begin
                r_merged <= w_merged;
            end
        end
    end

    assign LoadData   = r_load_data;
    assign MemAddress = {r_addr[31:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

    logic        Clk = 1'b0;
    logic        reset;
    logic        Req;
    logic        Ready;
    logic        IsStore;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] StoreData;
    logic        Done;
    logic        Fault;
    logic [31:0] LoadData;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] MemReadData;

    load_store_unit #(.MEM_BYTES(128)) dut (
        .Clk(Clk), .reset(reset), .Req(Req), .Ready(Ready),
        .IsStore(IsStore), .Funct3(Funct3), .Addr(Addr), .StoreData(StoreData),
        .Done(Done), .Fault(Fault), .LoadData(LoadData),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int act_cnt = 0;
    int op_id = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    logic [31:0] mem [0:31];
    assign MemReadData = (MemAddress < 32'd128) ? mem[MemAddress[6:2]] : 32'd0;

    always @(posedge Clk) begin
        if (MemWrite) begin
            if (MemAddress < 32'd128) mem[MemAddress[6:2]] = MemWriteData;
        end
    end

    typedef struct {
        int          id;
        logic        fault;
        logic [31:0] ld;
        int          lat;
        int          act;
        int          acc;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: count memory strobe cycles, compare each completion with the
    // oldest expectation.
    always @(negedge Clk) begin
        exp_t e;
        if (reset === 1'b1 && (MemRead === 1'b1 || MemWrite === 1'b1))
            chk("strobe_in_reset", {30'd0, MemRead, MemWrite}, 32'd0);
        if (MemWrite === 1'b1 && MemAddress >= 32'd128)
            chk("write_out_of_range", MemAddress, 32'd0);
        if (MemRead === 1'b1 || MemWrite === 1'b1) act_cnt++;
        if (Done === 1'b1) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got Done=1 expected no completion");
            end else begin
                e = sbq.pop_front();
                chk($sformatf("op%0d_fault", e.id), {31'd0, Fault}, {31'd0, e.fault});
                chk($sformatf("op%0d_latency", e.id), cyc - e.acc + 1, e.lat);
                chk($sformatf("op%0d_mem_cycles", e.id), act_cnt, e.act);
                chk($sformatf("op%0d_loaddata", e.id), LoadData, e.ld);
            end
            act_cnt = 0;
        end
    end

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
        @(negedge Clk);
        Req = 1'b1; IsStore = st; Funct3 = f3; Addr = a; StoreData = sd;
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (Ready !== 1'b1 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        ok = (Ready === 1'b1);
        if (!ok) chk("ready_timeout", {31'd0, Ready}, 32'd1);
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                         input logic flt, input logic [31:0] ld, input int lat, input int act);
        exp_t e;
        bit ok;
        drive(st, f3, a, sd);
        wait_ready(ok);
        if (!ok) begin
            Req = 1'b0;
            return;
        end
        @(posedge Clk);
        #1;
        op_id++;
        e.id = op_id; e.fault = flt; e.ld = ld; e.lat = lat; e.act = act; e.acc = cyc;
        sbq.push_back(e);
        Req = 1'b0; Addr = 32'hFFFF_FFFF; StoreData = 32'd0; Funct3 = 3'b111;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("done_timeout", sbq.size(), 32'd0);
            sbq.delete();
        end
    endtask

    task automatic op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                      input logic flt, input logic [31:0] ld, input int lat, input int act);
        issue(st, f3, a, sd, flt, ld, lat, act);
        wait_done();
    endtask

    initial begin
        bit ok;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[31] = 32'h7C7C_7C7C;
        reset = 1'b1; Req = 1'b0; IsStore = 1'b0; Funct3 = 3'b000; Addr = 32'd0; StoreData = 32'd0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("reset_ready", {31'd0, Ready}, 32'd0);
        chk("reset_done", {31'd0, Done}, 32'd0);
        chk("reset_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
        @(posedge Clk);
        #1 reset = 1'b0;
        @(negedge Clk);
        chk("idle_ready", {31'd0, Ready}, 32'd1);
        chk("reset_loaddata", LoadData, 32'd0);
        chk("reset_memaddress", MemAddress, 32'd0);
        chk("reset_memwdata", MemWriteData, 32'd0);
        chk("reset_fault", {31'd0, Fault}, 32'd0);

        // SW then LW
        op(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1);
        chk("sw_mem", mem[4], 32'hDEAD_BEEF);
        op(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 1);

        // SB into the top byte, then byte loads
        mem[4] = 32'h1122_3344;
        op(1'b1, 3'b000, 32'h13, 32'hFFFF_FFA5, 1'b0, 32'hDEAD_BEEF, 3, 2);
        chk("sb_mem", mem[4], 32'hA522_3344);
        op(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFF_FFA5, 2, 1);
        op(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h0000_00A5, 2, 1);
        op(1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'h0000_0044, 2, 1);

        // SH into the upper half, then halfword loads
        mem[8] = 32'h1122_3344;
        op(1'b1, 3'b001, 32'h22, 32'h0000_8001, 1'b0, 32'h0000_0044, 3, 2);
        chk("sh_mem", mem[8], 32'h8001_3344);
        op(1'b0, 3'b001, 32'h22, 32'h0, 1'b0, 32'hFFFF_8001, 2, 1);
        op(1'b0, 3'b101, 32'h22, 32'h0, 1'b0, 32'h0000_8001, 2, 1);
        op(1'b0, 3'b001, 32'h20, 32'h0, 1'b0, 32'h0000_3344, 2, 1);

        // Faults: LoadData held, no memory activity
        op(1'b0, 3'b010, 32'h06, 32'h0, 1'b1, 32'h0000_3344, 1, 0);
        op(1'b1, 3'b001, 32'h11, 32'h0000_1234, 1'b1, 32'h0000_3344, 1, 0);
        op(1'b1, 3'b010, 32'h80, 32'h5555_5555, 1'b1, 32'h0000_3344, 1, 0);
        op(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0000_3344, 1, 0);
        chk("fault_mem4", mem[4], 32'hA522_3344);
        chk("fault_mem8", mem[8], 32'h8001_3344);

        // Last in-range word
        op(1'b0, 3'b010, 32'h7C, 32'h0, 1'b0, 32'h7C7C_7C7C, 2, 1);

        // Reset during the WRITE cycle of an SB
        mem[4] = 32'h1122_3344;
        drive(1'b1, 3'b000, 32'h13, 32'hFFFF_FFA5);
        wait_ready(ok);
        @(posedge Clk);
        #1 Req = 1'b0;
        @(posedge Clk);
        #1 reset = 1'b1;
        @(negedge Clk);
        chk("rst_write_memwrite", {31'd0, MemWrite}, 32'd0);
        chk("rst_write_done", {31'd0, Done}, 32'd0);
        @(posedge Clk);
        #1 reset = 1'b0;
        @(negedge Clk);
        chk("rst_ready_after", {31'd0, Ready}, 32'd1);
        chk("rst_mem_unchanged", mem[4], 32'h1122_3344);
        chk("rst_loaddata", LoadData, 32'd0);
        act_cnt = 0;
        repeat (3) @(negedge Clk);

        // Req held through an SB, with a bogus pulse while busy
        mem[12] = 32'h0;
        issue(1'b1, 3'b000, 32'h13, 32'hFFFF_FFA5, 1'b0, 32'h0, 3, 2);
        Req = 1'b1; IsStore = 1'b1; Funct3 = 3'b010; Addr = 32'h30; StoreData = 32'hBAD0_BAD0;
        @(posedge Clk);
        #1 Req = 1'b0;
        @(posedge Clk);
        #1 Req = 1'b1;
        @(posedge Clk);
        #1 Req = 1'b0;
        wait_done();
        chk("busy_req_ignored", mem[12], 32'h0);
        chk("held_sb_mem", mem[4], 32'hA522_3344);
        op(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h0000_00A5, 2, 1);

        repeat (3) @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the EX/MEM pipeline register and the data memory and turns RISC-V load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned accesses to the memory. The data memory reads and writes whole words only, so this unit does the following:
- extracts and extends the addressed byte or halfword on loads;
- performs a read-modify-write for byte and halfword stores;
- flags misaligned, illegal and out-of-range accesses before they reach memory.

A multi-cycle FSM with a Req/Ready/Done handshake drives the memory.

## Interface
- MEM_BYTES, default 128: size of the data memory in bytes. Any access with Addr >= MEM_BYTES faults.
- Clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; one clock, reset sampled on the rising edge of Clk.
- Req  in  1  request valid; accepted on a rising edge where Req && Ready.
- Ready  out  1  unit idle and able to accept.
- IsStore  in  1  1 = store, 0 = load.
- Funct3  in  3  RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- Addr  in  32  byte address.
- StoreData  in  32  store source (rs2); low byte or halfword is used for SB/SH.
- Done  out  1  one-cycle completion pulse.
- Fault  out  1  valid only with Done; 1 = access rejected, no memory side effects.
- LoadData  out  32  extended load result; updated only by a successful load, held otherwise.
- MemAddress  out  32  to memory, always {addr[31:2],2'b00}.
- MemWriteData  out  32  to memory.
- MemWrite  out  1  to memory; write commits on the rising edge.
- MemRead  out  1  to memory.
- MemReadData  in  32  from memory; combinational, valid in the same cycle as MemRead.

## Operation
- On acceptance, the unit captures IsStore, Funct3, Addr and StoreData into internal registers. Req/Addr may change afterwards.
- FSM states: IDLE, LOAD, RMW_READ, WRITE, RESP.
- IDLE: Ready=1. On accept:
  - Fault condition → RESP with Fault.
  - Load → LOAD.
  - SW → WRITE.
  - SB/SH → RMW_READ.
- Fault conditions:
  - Funct3 not in the legal set for the op (011/110/111 for loads; anything but 000/001/010 for stores).
  - Halfword with addr[0]=1.
  - Word with addr[1:0]≠0.
  - Addr >= MEM_BYTES.
- LOAD: MemRead=1. Extracts the lane from MemReadData into LoadData at the edge. Next state RESP.
- Lane selection is little-endian:
  - Byte k = addr[1:0] → bits [8k+7:8k].
  - Halfword: addr[1]=0 → [15:0], addr[1]=1 → [31:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- RMW_READ: MemRead=1. Registers MemReadData with the store lane replaced by StoreData[7:0] or [15:0]; other bytes are preserved. Next state WRITE.
- WRITE: MemWrite=1. MemWriteData = StoreData (SW) or the merged word (SB/SH). Next state RESP.
- RESP: Done=1, Fault set as decided. Next state IDLE.
- Outside LOAD/RMW_READ/WRITE: MemRead=MemWrite=0, MemWriteData=0.
- Req while Ready=0 is ignored, with no queueing; the requester holds Req until it sees Ready.

## Timing
- Reset values: state IDLE, Done=0, Fault=0, LoadData=0, MemRead=0, MemWrite=0, MemWriteData=0, MemAddress=0.
- Ready = (state==IDLE) && !reset.
- Latency, from the accept edge to the Done cycle:
  - Fault: 1 cycle (RESP immediately after accept).
  - Load / SW: 2 cycles (LOAD or WRITE, then RESP).
  - SB/SH: 3 cycles (RMW_READ, WRITE, RESP).
- Throughput: a new request can be accepted at the first edge with state IDLE, i.e. one cycle after Done.
- Reset mid-operation:
  - MemRead and MemWrite are gated by !reset combinationally, so no write commits in any cycle where reset=1.
  - An interrupted SB/SH leaves the memory word unchanged.
  - The FSM is in IDLE after the edge; no Done is issued for the aborted request.
- LoadData is stable from the Done cycle until the next successful load's RESP.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → each Done 2 cycles after accept; LoadData=0xDEADBEEF, Fault=0.
- Word @0x10 = 0x11223344; SB StoreData=0xFFFFFFA5 @0x13 → word 0xA5223344, Done 3 cycles after accept. Then LB @0x13 → 0xFFFFFFA5; LBU @0x13 → 0x000000A5; LB @0x10 → 0x00000044.
- Word @0x20 = 0x11223344; SH 0x00008001 @0x22 → word 0x80013344. LH @0x22 → 0xFFFF8001; LHU @0x22 → 0x00008001; LH @0x20 → 0x00003344.
- Faults, each → Done+Fault 1 cycle after accept, no MemRead/MemWrite cycles, memory and LoadData unchanged:
  - LW @0x06
  - SH @0x11
  - SW @0x80 (MEM_BYTES=128)
  - Load Funct3=011
- Reset asserted in the WRITE cycle of SB @0x13 → MemWrite=0 that cycle, word unchanged, no Done. Ready=1 the first cycle reset=0.
- Req held high through a 3-cycle SB, plus a second Req pulse while busy → exactly one access performed; second request accepted only once Ready=1 again.
